// File: rtl/bru_pkg.sv
// bru_pkg -- shared types and default sizes for the branch resolve unit.
// Rev 1.0
`default_nettype none

package bru_pkg;

  localparam int BRU_DEPTH = 4;
  localparam int BRU_AW    = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_DRAIN    = 2'd2
  } bru_state_e;

  // Prediction record at the default address width; the top mirrors this layout for any AW.
  typedef struct packed {
    logic [BRU_AW-1:0] pc;
    logic              hit;
    logic [BRU_AW-1:0] target;
  } pred_rec_t;

endpackage

`default_nettype wire

// File: rtl/branch_resolve_if.sv
// branch_resolve_if -- IF/ID prediction, resolution and BTB update bundle.
// Rev 1.0
`default_nettype none

interface branch_resolve_if #(
  parameter int AW = 32
);
  logic          Pred_Valid_IN_IF;
  logic [AW-1:0] Pred_PC_IN_IF;
  logic          Pred_Hit_IN_IF;
  logic [AW-1:0] Pred_Target_IN_IF;
  logic          Resolve_Valid_IN_ID;
  logic [AW-1:0] Resolve_PC_IN_ID;
  logic          is_Branch_IN_ID;
  logic          is_Taken_IN_ID;
  logic [AW-1:0] Alt_PC_IN_ID;
  logic          Upd_Valid_OUT;
  logic [AW-1:0] Upd_PC_OUT;
  logic [AW-1:0] Upd_Target_OUT;
  logic          Redirect_OUT;
  logic [AW-1:0] Redirect_PC_OUT;
  logic          Queue_Full_OUT;
  logic [31:0]   Mispred_Count_OUT;

  modport master (
    output Pred_Valid_IN_IF, Pred_PC_IN_IF, Pred_Hit_IN_IF, Pred_Target_IN_IF,
           Resolve_Valid_IN_ID, Resolve_PC_IN_ID, is_Branch_IN_ID, is_Taken_IN_ID,
           Alt_PC_IN_ID,
    input  Upd_Valid_OUT, Upd_PC_OUT, Upd_Target_OUT, Redirect_OUT, Redirect_PC_OUT,
           Queue_Full_OUT, Mispred_Count_OUT
  );

  modport slave (
    input  Pred_Valid_IN_IF, Pred_PC_IN_IF, Pred_Hit_IN_IF, Pred_Target_IN_IF,
           Resolve_Valid_IN_ID, Resolve_PC_IN_ID, is_Branch_IN_ID, is_Taken_IN_ID,
           Alt_PC_IN_ID,
    output Upd_Valid_OUT, Upd_PC_OUT, Upd_Target_OUT, Redirect_OUT, Redirect_PC_OUT,
           Queue_Full_OUT, Mispred_Count_OUT
  );
endinterface

`default_nettype wire

// File: rtl/bru_pred_fifo.sv
// bru_pred_fifo -- in-flight prediction queue with synchronous clear.
// Rev 1.0
`default_nettype none

module bru_pred_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 65
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     clr,
  input  wire logic                     push,
  input  wire logic                     pop,
  input  wire logic [W-1:0]             wdata,
  output logic      [W-1:0]             rdata,
  output logic                          full,
  output logic                          empty,
  output logic      [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/branch_resolve.sv
// branch_resolve -- checks BTB predictions at ID, redirects fetch and trains the BTB.
// Rev 1.0. Optional macro BRU_STATS_EN enables the mispredict counter.
`default_nettype none

module branch_resolve
  import bru_pkg::*;
#(
  parameter int DEPTH = BRU_DEPTH,
  parameter int AW    = BRU_AW
) (
  input  wire logic        CLK,
  input  wire logic        RESET,
  input  wire logic        STALL,
  branch_resolve_if.slave  bus
);
  localparam int RW = 2 * AW + 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic          hit;
    logic [AW-1:0] target;
  } rec_t;

  bru_state_e state;
  bru_state_e state_nxt;

  rec_t          push_rec;
  rec_t          fifo_head;
  rec_t          head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  logic          idle_go;
  logic          push_req;
  logic          pop_req;
  logic          actual_taken;
  logic          mispred;
  logic          need_upd;
  logic          mis_pop;

  logic          upd_pend;
  logic [AW-1:0] upd_pc;
  logic [AW-1:0] upd_tgt;
  logic [AW-1:0] redir_pc;

  assign idle_go  = (state == ST_IDLE) & ~STALL;
  assign push_req = bus.Pred_Valid_IN_IF & idle_go & (~fifo_full | pop_req);
  assign pop_req  = bus.Resolve_Valid_IN_ID & idle_go;
  assign push_rec = '{pc: bus.Pred_PC_IN_IF, hit: bus.Pred_Hit_IN_IF,
                      target: bus.Pred_Target_IN_IF};

  bru_pred_fifo #(
    .DEPTH (DEPTH),
    .W     (RW)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .clr   (mis_pop),
    .push  (push_req),
    .pop   (pop_req),
    .wdata (push_rec),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // An unmatched resolve behaves as a not-predicted fetch of the resolved PC.
  always_comb begin
    head = fifo_head;
    if (fifo_empty) head = '{pc: bus.Resolve_PC_IN_ID, hit: 1'b0, target: '0};
  end

  assign actual_taken = bus.is_Branch_IN_ID & bus.is_Taken_IN_ID;
  assign mispred  = (actual_taken != head.hit) |
                    (actual_taken & (head.target != bus.Alt_PC_IN_ID));
  assign need_upd = actual_taken & (~head.hit | (head.target != bus.Alt_PC_IN_ID));
  assign mis_pop  = pop_req & mispred;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (mis_pop) state_nxt = ST_REDIRECT;
      ST_REDIRECT: if (!STALL)  state_nxt = ST_DRAIN;
      ST_DRAIN:    if (!STALL)  state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      upd_pend <= 1'b0;
      upd_pc   <= '0;
      upd_tgt  <= '0;
      redir_pc <= '0;
    end else begin
      state <= state_nxt;
      // A pending BTB write survives a stall and fires once STALL drops.
      if (pop_req && need_upd) begin
        upd_pend <= 1'b1;
        upd_pc   <= bus.Resolve_PC_IN_ID;
        upd_tgt  <= bus.Alt_PC_IN_ID;
      end else if (!STALL) begin
        upd_pend <= 1'b0;
      end
      if (mis_pop)
        redir_pc <= actual_taken ? bus.Alt_PC_IN_ID : bus.Resolve_PC_IN_ID + AW'(8);
    end
  end

  assign bus.Upd_Valid_OUT   = upd_pend & ~STALL;
  assign bus.Upd_PC_OUT      = upd_pc;
  assign bus.Upd_Target_OUT  = upd_tgt;
  assign bus.Redirect_OUT    = (state == ST_REDIRECT) & ~STALL;
  assign bus.Redirect_PC_OUT = redir_pc;
  assign bus.Queue_Full_OUT  = (fifo_count == CW'(DEPTH));

`ifdef BRU_STATS_EN
  logic [31:0] mis_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)        mis_cnt <= '0;
    else if (mis_pop) mis_cnt <= mis_cnt + 32'd1;
  end

  assign bus.Mispred_Count_OUT = mis_cnt;
`else
  assign bus.Mispred_Count_OUT = 32'd0;
`endif

endmodule

`default_nettype wire

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL expose parameter DEPTH, default 4, meaning in-flight prediction queue entries (power of two, 2..16).
REQ-002 SHALL expose parameter AW, default 32, meaning PC/target width.
REQ-003 CLK  in  1  sole clock, all state on rising edge.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 STALL  in  1  pipeline stall; freezes all state.
REQ-006 Pred_Valid_IN_IF  in  1  IF issued a fetch carrying a BTB prediction record.
REQ-007 Pred_PC_IN_IF  in  AW  fetched instruction PC.
REQ-008 Pred_Hit_IN_IF  in  1  BTB hit (predicted taken).
REQ-009 Pred_Target_IN_IF  in  AW  BTB predicted target.
REQ-010 Resolve_Valid_IN_ID  in  1  ID resolves the oldest outstanding fetch.
REQ-011 Resolve_PC_IN_ID  in  AW  resolved instruction PC.
REQ-012 is_Branch_IN_ID  in  1  resolved instruction is a branch or jump.
REQ-013 is_Taken_IN_ID  in  1  branch actually taken.
REQ-014 Alt_PC_IN_ID  in  AW  actual taken target.
REQ-015 Upd_Valid_OUT  out  1  one-cycle BTB write strobe.
REQ-016 Upd_PC_OUT  out  AW  BTB entry PC to install.
REQ-017 Upd_Target_OUT  out  AW  BTB target to install.
REQ-018 Redirect_OUT  out  1  one-cycle fetch redirect pulse.
REQ-019 Redirect_PC_OUT  out  AW  correct next fetch PC.
REQ-020 Queue_Full_OUT  out  1  queue full; IF must not issue Pred_Valid.
REQ-021 Mispred_Count_OUT  out  32  mispredict count (see Configuration).

Function
REQ-022 SHALL push {PC, hit, target} when Pred_Valid=1, STALL=0, queue not full, state IDLE; push while full SHALL be dropped.
REQ-023 SHALL pop head when Resolve_Valid=1, STALL=0, state IDLE; pop on empty SHALL use record {Resolve_PC, 0, 0}.
REQ-024 Simultaneous push+pop when full SHALL both succeed; count unchanged; pointers wrap modulo DEPTH.
REQ-025 actual_taken = is_Branch & is_Taken; mispredict = (actual_taken != head.hit) | (actual_taken & head.target != Alt_PC).
REQ-026 Non-branch with head.hit=1 SHALL count as mispredict (stale BTB alias).
REQ-027 Redirect_PC = actual_taken ? Alt_PC : Resolve_PC + 8 (delay slot), AW-bit wrap-around.
REQ-028 Upd_Valid SHALL pulse exactly one cycle after a pop where actual_taken & (!head.hit | head.target != Alt_PC), with Upd_PC=Resolve_PC, Upd_Target=Alt_PC.
REQ-029 FSM states IDLE, REDIRECT, DRAIN; IDLE->REDIRECT on mispredicting pop; REDIRECT->DRAIN; DRAIN->IDLE; all transitions gated by STALL=0.
REQ-030 Redirect_OUT SHALL be 1 only in REDIRECT (1 cycle after the mispredicting pop); Redirect_PC_OUT registered with it.
REQ-031 Queue SHALL be cleared on the edge entering REDIRECT; pushes and pops SHALL be ignored in REDIRECT and DRAIN (wrong path).
REQ-032 Upd_Valid and Redirect may assert in the same cycle.
REQ-033 STALL=1 SHALL hold queue, FSM, counters and data outputs; Upd_Valid_OUT and Redirect_OUT SHALL be forced 0 and the pending pulse re-issued after STALL drops.
REQ-034 Queue_Full_OUT SHALL be combinational from the entry count.

Reset
REQ-035 RESET=1 SHALL asynchronously empty the queue, set state IDLE, clear all outputs and counters to 0, overriding STALL.
REQ-036 RESET mid-REDIRECT/DRAIN SHALL abort recovery; first post-reset cycle accepts pushes.

Configuration
REQ-037 Macro BRU_STATS_EN defined: Mispred_Count_OUT increments (wrapping) on each mispredicting pop.
REQ-038 Macro undefined: port remains, tied to 0, no counter logic.

Structure
REQ-039 Package bru_pkg SHALL hold the state enum, prediction-record struct, and DEPTH/AW defaults.
REQ-040 Sub-module bru_pred_fifo SHALL implement the queue (push/pop/clear/full/empty/count).

Verification
REQ-041 Push PC=0x100 hit=1 tgt=0x200; resolve taken Alt=0x200 -> no Redirect, no Upd.
REQ-042 Push PC=0x100 hit=0; resolve taken Alt=0x300 -> next cycle Upd(0x100,0x300) and Redirect 0x300 one cycle; DRAIN ignores push; count=1 with BRU_STATS_EN.
REQ-043 Push hit=1 tgt=0x200; resolve not-taken PC=0x100 -> Redirect 0x108, no Upd.
REQ-044 Fill 4 entries -> Queue_Full=1, 5th push dropped; simultaneous push+pop at full -> full stays 1, order preserved.
REQ-045 Mispredict with STALL=1 on following cycle -> no pulses during stall, single Redirect after release; RESET during DRAIN -> outputs 0, IDLE.
